// File: rtl/data_mem_wbuf.sv
// data_mem_wbuf: word-organised data memory on the ALU load/store bus, with
// an in-order posted write buffer in front of a single-write-port array.
//   clk, rst     : clock, asynchronous active-high reset
//   ram_address  : byte address; word index = ram_address[$clog2(MEM_DEPTH)+1:2]
//   ram_we       : 1 = store (ALU drives ram_data), 0 = load
//   ram_data     : bidirectional data; driven here only on loads (latency 0)
//   wb_count     : occupied write-buffer entries
//   wb_full      : wb_count == WB_DEPTH
//   wb_empty     : wb_count == 0
//   addr_err     : sticky out-of-range flag (only with DMEM_ADDR_CHECK_EN)
// Optional feature macro: DMEM_ADDR_CHECK_EN (range check, drop/zero on
// out-of-range accesses). Without it, upper index bits are ignored.
module data_mem_wbuf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_WIDTH  = 31,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned WB_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RAM_WIDTH-1:0]          ram_address,
  input  logic                          ram_we,
  inout  wire  [DATA_WIDTH-1:0]         ram_data,
  output logic [$clog2(WB_DEPTH+1)-1:0] wb_count,
  output logic                          wb_full,
  output logic                          wb_empty
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic                          addr_err
`endif
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned PTR_W = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);

  // Storage: the array is never reset; buffer slots are qualified by count
  logic [DATA_WIDTH-1:0] mem    [MEM_DEPTH];
  logic [IDX_W-1:0]      tag_q  [WB_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [WB_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0]      idx_c;
  logic                  push_c;
  logic                  pop_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  unused_addr_c;

  assign idx_c         = ram_address[IDX_W+1:2];
  assign unused_addr_c = ^{ram_address[1:0], ram_address[RAM_WIDTH-1:IDX_W+2]};

`ifdef DMEM_ADDR_CHECK_EN
  logic oor_c;
  logic addr_err_q, addr_err_d;

  // Any nonzero bit above the word index means the byte address >= MEM_DEPTH*4
  assign oor_c      = |ram_address[RAM_WIDTH-1:IDX_W+2];
  assign push_c     = ram_we & ~oor_c;
  assign addr_err_d = addr_err_q | oor_c;
  assign addr_err   = addr_err_q;
`else
  assign push_c = ram_we;
`endif

  // Drain on idle cycles, or alongside a push when full so no store is lost
  assign pop_c = (count_q != '0) && (!ram_we || (full_q && push_c));

  // Next-state for pointers, occupancy and the registered flags
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d  = (count_d == CNT_W'(WB_DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state; reset discards every buffered store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
`ifdef DMEM_ADDR_CHECK_EN
      addr_err_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
`ifdef DMEM_ADDR_CHECK_EN
      addr_err_q <= addr_err_d;
`endif
    end
  end

  // Buffer slot write; when full, the head slot is overwritten in the same
  // edge it drains, which is safe because the array write sees the old value
  always_ff @(posedge clk) begin
    if (push_c) begin
      tag_q[wr_ptr_q]  <= idx_c;
      data_q[wr_ptr_q] <= ram_data;
    end
  end

  // Single array write port, fed only by the buffer head
  always_ff @(posedge clk) begin
    if (pop_c) begin
      mem[tag_q[rd_ptr_q]] <= data_q[rd_ptr_q];
    end
  end

  // Load path: walk oldest to youngest so the youngest matching entry wins
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot      = '0;
    rd_data_c = mem[idx_c];
    for (int k = 0; k < int'(WB_DEPTH); k++) begin
      slot = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (tag_q[slot] == idx_c)) begin
        rd_data_c = data_q[slot];
      end
    end
`ifdef DMEM_ADDR_CHECK_EN
    if (oor_c) begin
      rd_data_c = '0;
    end
`endif
  end

  assign ram_data = ram_we ? {DATA_WIDTH{1'bz}} : rd_data_c;

  assign wb_count = count_q;
  assign wb_full  = full_q;
  assign wb_empty = empty_q;

endmodule

// File: tb/tb_data_mem_wbuf.sv
// tb_data_mem_wbuf: directed, self-checking bench for data_mem_wbuf.
// Load results are queued as expectations when the load is driven and
// popped when ram_data is sampled. Honours DMEM_ADDR_CHECK_EN.
module tb_data_mem_wbuf;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 31;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  wire  [DW-1:0] ram_data;
  logic [2:0]    wb_count;
  logic          wb_full;
  logic          wb_empty;
`ifdef DMEM_ADDR_CHECK_EN
  logic          addr_err;
`endif

  int            tests;
  int            fails;
  logic [DW-1:0] exp_q[$];

  assign ram_data = we ? wdata : {DW{1'bz}};

  data_mem_wbuf #(
    .DATA_WIDTH(32),
    .RAM_WIDTH (31),
    .MEM_DEPTH (1024),
    .WB_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ram_address(addr),
    .ram_we     (we),
    .ram_data   (ram_data),
    .wb_count   (wb_count),
    .wb_full    (wb_full),
    .wb_empty   (wb_empty)
`ifdef DMEM_ADDR_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Occupancy plus the two flags implied by it
  task automatic check_state(input string tag, input int cnt);
    check({tag, "_count"}, DW'(wb_count), DW'(cnt));
    check({tag, "_full"},  DW'(wb_full),  DW'(cnt == 4));
    check({tag, "_empty"}, DW'(wb_empty), DW'(cnt == 0));
  endtask

  // Compare ram_data against the oldest queued expectation
  task automatic sb_check(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: observed empty scoreboard, expected a queued value", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, ram_data, e);
    end
  endtask

  // Store: drive at negedge, return 1ns after the committing posedge
  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  // Load: drive at negedge, check combinational data, then pass the edge
  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    @(negedge clk);
    we    = 1'b0;
    addr  = a;
    wdata = '0;
    exp_q.push_back(exp);
    #1;
    sb_check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_state("reset", 0);
`ifdef DMEM_ADDR_CHECK_EN
    check("reset_addr_err", DW'(addr_err), DW'(0));
`endif

    // Preload the array through the buffer, drain, then reset
    store(31'h10, 32'h0000_1010);
    store(31'h60, 32'h0000_6060);
    store(31'h64, 32'h0000_6464);
    store(31'h68, 32'h0000_6868);
    check_state("preload_full", 4);
    repeat (4) idle();
    check_state("preload_drained", 0);
    pulse_reset();
    #1;
    check_state("post_reset", 0);

    load(31'h10, 32'h0000_1010, "rd_preload_0x10");

    // Forwarding of a single store, then drain to the array
    store(31'h20, 32'hDEAD_BEEF);
    check("hiz_while_store", ram_data, 32'hDEAD_BEEF);
    check_state("one_store", 1);
    load(31'h20, 32'hDEAD_BEEF, "fwd_0x20");
    check_state("after_drain_0x20", 0);
    load(31'h20, 32'hDEAD_BEEF, "array_0x20");

    // Duplicate index: youngest wins while both, or only it, is buffered
    store(31'h40, 32'h0000_0011);
    store(31'h40, 32'h0000_0022);
    check_state("dup_two", 2);
    load(31'h40, 32'h0000_0022, "dup_fwd_both");
    check_state("dup_one", 1);
    load(31'h40, 32'h0000_0022, "dup_fwd_young");
    check_state("dup_none", 0);
    load(31'h40, 32'h0000_0022, "dup_array");

    // Fill, then store into a full buffer: drain and push in one edge
    store(31'h00, 32'h0000_00A0);
    store(31'h04, 32'h0000_00A4);
    store(31'h08, 32'h0000_00A8);
    store(31'h0C, 32'h0000_00AC);
    check_state("fill4", 4);
    store(31'h10, 32'h0000_0055);
    check_state("full_push", 4);
    load(31'h00, 32'h0000_00A0, "full_rd_0x00");
    check_state("full_rd1", 3);
    load(31'h04, 32'h0000_00A4, "full_rd_0x04");
    load(31'h08, 32'h0000_00A8, "full_rd_0x08");
    load(31'h0C, 32'h0000_00AC, "full_rd_0x0C");
    load(31'h10, 32'h0000_0055, "full_rd_0x10");
    check_state("full_drained", 0);

    // Reset mid-cycle with three pending stores discards them at once
    store(31'h60, 32'h0000_BAD0);
    store(31'h64, 32'h0000_BAD4);
    store(31'h68, 32'h0000_BAD8);
    check_state("three_pending", 3);
    @(negedge clk);
    we = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_state("async_reset", 0);
    #1;
    rst = 1'b0;
    load(31'h60, 32'h0000_6060, "discard_0x60");
    load(31'h64, 32'h0000_6464, "discard_0x64");
    load(31'h68, 32'h0000_6868, "discard_0x68");

`ifdef DMEM_ADDR_CHECK_EN
    // Out-of-range store dropped, sticky error, read returns zero
    check("pre_oor_addr_err", DW'(addr_err), DW'(0));
    store(31'h1000, 32'h0000_7777);
    check_state("oor_store", 0);
    check("oor_addr_err_set", DW'(addr_err), DW'(1));
    load(31'h1000, 32'h0000_0000, "oor_read_zero");
    idle();
    check("oor_addr_err_sticky", DW'(addr_err), DW'(1));
    load(31'h00, 32'h0000_00A0, "oor_no_alias");
    pulse_reset();
    #1;
    check("oor_addr_err_cleared", DW'(addr_err), DW'(0));
`else
    // Upper index bits ignored: addresses wrap modulo MEM_DEPTH words
    store(31'h1024, 32'h9999_0009);
    check_state("wrap_store", 1);
    load(31'h24, 32'h9999_0009, "wrap_fwd_0x24");
    load(31'h24, 32'h9999_0009, "wrap_array_0x24");
    load(31'h1010, 32'h0000_0055, "wrap_rd_0x1010");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_wbuf.md
Name: data_mem_wbuf

Overview:
- Data-memory responder on the ALU load/store bus (ram_address, ram_we, inout ram_data).
- Word-organised, single-write-port RAM with asynchronous read, so a load completes in the same cycle the ALU presents the address.
- Stores are posted into an in-order write buffer; the buffer drains to the array on idle cycles.
- Loads forward from pending buffered stores.

Parameters:
- DATA_WIDTH, 32, bus and word width.
- RAM_WIDTH, 31, byte-address width of ram_address.
- MEM_DEPTH, 1024, number of words in the array; power of two.
- WB_DEPTH, 4, write-buffer entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- ram_address  input  RAM_WIDTH  byte address; word index = ram_address[$clog2(MEM_DEPTH)+1:2], bits [1:0] ignored.
- ram_we  input  1  1 = store this cycle (ALU drives ram_data); 0 = read.
- ram_data  inout  DATA_WIDTH  driven by this block only when ram_we=0, otherwise high-Z.
- wb_count  output  $clog2(WB_DEPTH+1)  number of occupied buffer entries.
- wb_full  output  1  wb_count == WB_DEPTH.
- wb_empty  output  1  wb_count == 0.

Behaviour:
- Reset (async assert, applied immediately):
  - Read/write pointers and wb_count go to 0; wb_full=0, wb_empty=1.
  - Buffered stores are discarded, including any reset mid-drain.
  - Array contents are not reset.
- Read path (combinational, ram_we=0):
  - Compare the index against all valid buffer entries and return the youngest match.
  - On no match, return array[index].
  - ram_data is valid in the same cycle; latency 0.
- Store, ram_we=1 at posedge:
  - Push {index, ram_data} at the tail; latency 1 into the buffer.
  - Duplicate indices are allowed; the youngest entry wins on forwarding, and drain order is preserved.
- Drain:
  - At posedge with ram_we=0 and the buffer not empty, write the head entry to the array and pop it.
  - Drain rate is one entry per idle cycle.
- Full buffer with ram_we=1:
  - Head drains to the array and the new entry pushes in the same edge.
  - wb_count is unchanged; no store is ever lost and there is no stall.
- Not full with ram_we=1: push only, no drain; wb_count increments by 1.
- Array write port: at most one array write per cycle.
- Pointers are $clog2(WB_DEPTH) bits and wrap modulo WB_DEPTH; wb_count is kept separately to distinguish full from empty.
- Address handling without the optional feature: index bits above $clog2(MEM_DEPTH)+1 are ignored (wrap modulo MEM_DEPTH).
- X/Z on ram_address while ram_we=0 has no effect on state.

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN.
- Enabled:
  - Adds output port addr_err (1 bit, reset 0).
  - addr_err sets sticky at posedge when any access has ram_address >= MEM_DEPTH*4, and clears only on rst.
  - Out-of-range reads drive 0 onto ram_data.
  - Out-of-range stores are dropped: no push, wb_count unchanged.
- Disabled: no addr_err port; out-of-range addresses wrap as above.

Test Plan:
- Reset, then read address 0x10 → ram_data equals preloaded array word. Check wb_empty=1, wb_count=0, and ram_data is high-Z while ram_we=1.
- Store 0xDEADBEEF to 0x20 (1 cycle), then read 0x20 next cycle → 0xDEADBEEF via forwarding with wb_count=1. After one more idle cycle: wb_count=0 and array[8]=0xDEADBEEF.
- Stores 0x11 then 0x22 to 0x40 back-to-back, then read 0x40 → 0x22. After 2 idle cycles the array holds 0x22.
- Stores to 0x00,0x04,0x08,0x0C → wb_full=1, wb_count=4. Fifth store 0x55 to 0x10 → word 0x00 written to the array, wb_count stays 4. Reads of all five addresses return the stored values.
- Fill 3 entries, assert rst mid-cycle → wb_count=0 immediately. Reads return the old array data, proving the buffered stores were discarded.
- DMEM_ADDR_CHECK_EN: store to 0x1000 (MEM_DEPTH=1024) → addr_err=1, wb_count unchanged. A subsequent read of 0x1000 returns 0 and addr_err stays 1 until rst.
